inst_mem_pipe: RTL and testbench
================================

INST_MEM_PIPE -- requirements
Module: inst_mem_pipe

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 256, number of words; SHALL be a power of two, at least 2.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), word-index width.
REQ-004 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; SHALL be 4-byte aligned.
REQ-005 Parameter NOP_WORD, default all-zero, word returned on reset, flush or fault.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 fetch_req  input  1  fetch request for the address on pc.
REQ-009 pc  input  32  byte address of the requested instruction.
REQ-010 fetch_ready  output  1  fetch accepted this cycle when fetch_req and fetch_ready are both high.
REQ-011 stall  input  1  downstream hold; freezes the output stage.
REQ-012 flush  input  1  discards the output stage and any fetch accepted in the same cycle.
REQ-013 instruction  output  DATA_W  registered instruction word.
REQ-014 inst_valid  output  1  instruction holds a valid result.
REQ-015 inst_fault  output  1  the result came from an out-of-range or misaligned pc.
REQ-016 ld_en  input  1  program-load write strobe.
REQ-017 ld_addr  input  ADDR_W  word index to write.
REQ-018 ld_data  input  DATA_W  word to write.

Function
REQ-019 Storage SHALL be a single-port DEPTH x DATA_W array; reset SHALL NOT alter its contents.
REQ-020 fetch_ready SHALL equal (not ld_en) and (not stall) and reset_n.
REQ-021 A load SHALL write ld_data to ld_addr on the clock edge; a load has priority over a fetch.
REQ-022 Offset = pc - BASE_ADDR, computed as a 32-bit unsigned value.
REQ-023 A fetch is in range when offset < DEPTH*4 and pc[1:0] == 0; word index = offset[ADDR_W+1:2].
REQ-024 Read latency SHALL be one cycle: an accepted fetch at edge N drives instruction and inst_valid=1 after edge N.
REQ-025 An in-range fetch SHALL return the stored word with inst_fault=0.
REQ-026 An out-of-range or misaligned fetch SHALL return NOP_WORD with inst_valid=1 and inst_fault=1.
REQ-027 With stall high, instruction, inst_valid and inst_fault SHALL hold their values.
REQ-028 A cycle with no accepted fetch, no stall and no flush SHALL clear inst_valid and inst_fault and drive NOP_WORD.
REQ-029 flush SHALL override stall and any fetch accepted in the same cycle: on the next edge inst_valid=0, inst_fault=0 and instruction=NOP_WORD.
REQ-030 A load and a rejected fetch in the same cycle SHALL produce the REQ-028 outcome, unless stall is high (REQ-027 then applies).
REQ-031 A fetch to a word written in an earlier cycle SHALL return the new data.
REQ-032 The address comparison SHALL NOT wrap: a pc below BASE_ADDR gives an offset of at least DEPTH*4 and is therefore a fault.

Reset
REQ-033 While reset_n is low: instruction=NOP_WORD, inst_valid=0, inst_fault=0 and fetch_ready=0, all immediately and independent of clk.
REQ-034 A reset asserted during operation SHALL discard the output stage; the first fetch can be accepted on the first edge after reset_n rises.
REQ-035 A load cycle during reset SHALL be ignored.

Verification
REQ-036 Load words 0..3 with 0x20010001, 0x20230003, 0x20050005, 0x00231020; fetch pc 0,4,8,12 back-to-back -> one cycle later each word appears in order, with inst_valid=1 and inst_fault=0.
REQ-037 Defaults; fetch pc=0x400 and then pc=0x6 -> NOP_WORD, inst_valid=1, inst_fault=1 for both.
REQ-038 Fetch pc=4, then assert stall for 3 cycles with fetch_req high -> instruction holds word 1 and fetch_ready=0 throughout; the fetch is accepted in the cycle stall drops.
REQ-039 Assert ld_en (addr 2, data 0xDEADBEEF) and fetch_req pc=8 in the same cycle -> fetch_ready=0 and inst_valid=0 next cycle; re-fetch pc=8 -> 0xDEADBEEF.
REQ-040 Accept a fetch with flush high in the same cycle -> inst_valid=0 next cycle; flush while stall is high -> inst_valid=0.
REQ-041 Drop reset_n mid-fetch-stream, asynchronous to clk -> all outputs clear immediately and memory contents are preserved; after release, fetch pc=0 -> the preloaded word 0.

Source files
------------

// File: rtl/inst_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_pipe
// Brief    : Loadable instruction memory with a one-cycle registered fetch
//            stage, supporting stall, flush, and fault reporting.
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_pipe #(
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         DEPTH     = 256,
  parameter int unsigned         ADDR_W    = $clog2(DEPTH),
  parameter logic [31:0]         BASE_ADDR = 32'h0000_0000,
  parameter logic [DATA_W-1:0]   NOP_WORD  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [31:0]       pc,
  output logic              fetch_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instruction,
  output logic              inst_valid,
  output logic              inst_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  // Window size kept one bit wider so DEPTH*4 never overflows 32 bits.
  localparam logic [32:0] C_SPAN_BYTES = 33'(DEPTH) * 33'd4;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  logic [31:0]       w_offset;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_idx;
  logic              w_fetch_acc;
  logic              w_ld_we;

  // A pc below BASE_ADDR wraps to a huge offset and so falls out of range.
  assign w_offset    = pc - BASE_ADDR;
  assign w_in_range  = ({1'b0, w_offset} < C_SPAN_BYTES) && (pc[1:0] == 2'b00);
  assign w_idx       = w_offset[ADDR_W+1:2];

  assign fetch_ready = ~ld_en & ~stall & reset_n;
  assign w_fetch_acc = fetch_req & fetch_ready;
  assign w_ld_we     = ld_en & reset_n;

  always_ff @(posedge clk) begin
    if (w_ld_we) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    // Flush wins over stall; otherwise stall freezes the stage.
    if (flush || !stall) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
      if (!flush && w_fetch_acc) begin
        valid_d = 1'b1;
        fault_d = ~w_in_range;
        instr_d = w_in_range ? mem_q[w_idx] : NOP_WORD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign instruction = instr_q;
  assign inst_valid  = valid_q;
  assign inst_fault  = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem_pipe
// Brief    : Scoreboard bench for inst_mem_pipe with directed and random fetches.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_mem_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam logic [31:0] BASE   = 32'h0000_0200;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              fetch_req = 1'b0;
  logic [31:0]       pc = '0;
  logic              fetch_ready;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] instruction;
  logic              inst_valid;
  logic              inst_fault;
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;

  inst_mem_pipe #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE),
    .NOP_WORD (NOP)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fetch_req  (fetch_req),
    .pc         (pc),
    .fetch_ready(fetch_ready),
    .stall      (stall),
    .flush      (flush),
    .instruction(instruction),
    .inst_valid (inst_valid),
    .inst_fault (inst_fault),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        fault;
    logic [31:0] word;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [DEPTH];

  // Reference: plain integer arithmetic on the byte address.
  function automatic exp_t ref_fetch(input logic [31:0] p);
    longint unsigned a  = longint'(p);
    longint unsigned lo = longint'(BASE);
    longint unsigned hi = longint'(BASE) + longint'(DEPTH) * 4;
    exp_t r;
    if ((a % 4) != 0 || a < lo || a >= hi) begin
      r.fault = 1'b1;
      r.word  = NOP;
    end else begin
      r.fault = 1'b0;
      r.word  = ref_mem[int'((a - lo) / 4)];
    end
    return r;
  endfunction

  // One cycle of stimulus; the expected result is queued at the edge it is produced on.
  task automatic drive(input logic fr, input logic [31:0] p, input logic st, input logic fl,
                       input logic le, input logic [ADDR_W-1:0] la, input logic [31:0] ld);
    fetch_req = fr;
    pc        = p;
    stall     = st;
    flush     = fl;
    ld_en     = le;
    ld_addr   = la;
    ld_data   = ld;
    @(posedge clk);
    if (reset_n && fr && !le && !st && !fl) sb_q.push_back(ref_fetch(p));
    if (reset_n && le) ref_mem[la] = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 32'h0);
  endtask

  // Monitor: rebuilds the expected output stage from the queue and edge-time controls.
  logic        e_stall = 1'b0, e_flush = 1'b0, e_rst = 1'b0;
  logic        mv = 1'b0, mf = 1'b0;
  logic [31:0] mw = NOP;

  always @(posedge clk) begin
    e_stall = stall;
    e_flush = flush;
    e_rst   = reset_n;
  end

  always @(negedge clk) begin
    exp_t t;
    if (!reset_n || !e_rst) begin
      sb_q.delete();
      mv = 1'b0; mf = 1'b0; mw = NOP;
    end else if (e_flush) begin
      mv = 1'b0; mf = 1'b0; mw = NOP;
    end else if (!e_stall) begin
      if (sb_q.size() > 0) begin
        t  = sb_q.pop_front();
        mv = 1'b1; mf = t.fault; mw = t.word;
      end else begin
        mv = 1'b0; mf = 1'b0; mw = NOP;
      end
    end
    chk("out{v,f,instr}", {30'h0, inst_valid, inst_fault, instruction}, {30'h0, mv, mf, mw});
    chk("fetch_ready", {63'h0, fetch_ready}, {63'h0, (~ld_en & ~stall & reset_n)});
  end

  logic [31:0] prog [4];
  logic [31:0] rpc;
  int unsigned rsel;

  initial begin
    prog[0] = 32'h2001_0001;
    prog[1] = 32'h2023_0003;
    prog[2] = 32'h2005_0005;
    prog[3] = 32'h0023_1020;

    // Asynchronous reset assertion before any clock edge.
    #2 reset_n = 1'b0;
    #1 chk("rst_async_init", {60'h0, fetch_ready, inst_valid, inst_fault, 1'b0} ^ {28'h0, instruction, 4'h0},
           {28'h0, NOP, 4'h0});
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Program load.
    for (int i = 0; i < int'(DEPTH); i++)
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, ADDR_W'(i), (i < 4) ? prog[i] : $urandom);

    // Back-to-back fetches of the first four words.
    for (int i = 0; i < 4; i++) drive(1'b1, BASE + 32'(4 * i), 1'b0, 1'b0, 1'b0, '0, 32'h0);
    idle();

    // Fault cases and range boundaries.
    drive(1'b1, BASE + 32'(DEPTH * 4), 1'b0, 1'b0, 1'b0, '0, 32'h0);
    drive(1'b1, BASE + 32'h6,          1'b0, 1'b0, 1'b0, '0, 32'h0);
    drive(1'b1, 32'h0000_0100,         1'b0, 1'b0, 1'b0, '0, 32'h0);
    drive(1'b1, 32'hFFFF_FFFC,         1'b0, 1'b0, 1'b0, '0, 32'h0);
    drive(1'b1, BASE - 32'h4,          1'b0, 1'b0, 1'b0, '0, 32'h0);
    drive(1'b1, BASE + 32'(DEPTH * 4 - 4), 1'b0, 1'b0, 1'b0, '0, 32'h0);
    idle();

    // Stall holds the stage and blocks the pending fetch until released.
    drive(1'b1, BASE + 32'h4, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    repeat (3) drive(1'b1, BASE + 32'h8, 1'b1, 1'b0, 1'b0, '0, 32'h0);
    drive(1'b1, BASE + 32'h8, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    idle();

    // Load collides with fetch; then the rewritten word is fetched.
    drive(1'b1, BASE + 32'h8, 1'b0, 1'b0, 1'b1, 6'd2, 32'hDEAD_BEEF);
    drive(1'b1, BASE + 32'h8, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    idle();

    // Flush with an accepted fetch, and flush overriding stall.
    drive(1'b1, BASE + 32'hC, 1'b0, 1'b1, 1'b0, '0, 32'h0);
    drive(1'b1, BASE + 32'hC, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    drive(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, '0, 32'h0);
    idle();

    // Randomised mix of fetches, loads, stalls and flushes.
    for (int i = 0; i < 400; i++) begin
      rsel = $urandom_range(0, 99);
      if (rsel < 75)      rpc = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (rsel < 85) rpc = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      else                rpc = $urandom;
      drive(($urandom_range(0, 99) < 80), rpc, ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15),
            ADDR_W'($urandom), $urandom);
    end
    idle();

    // Reset dropped mid-stream between clock edges; a load during reset is ignored.
    drive(1'b1, BASE + 32'h0, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    drive(1'b1, BASE + 32'h4, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_mid", {60'h0, fetch_ready, inst_valid, inst_fault, 1'b0} ^ {28'h0, instruction, 4'h0},
           {28'h0, NOP, 4'h0});
    drive(1'b1, BASE + 32'h8, 1'b0, 1'b0, 1'b1, 6'd0, 32'hBAD0_BAD0);
    drive(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 6'd0, 32'hBAD1_BAD1);
    reset_n = 1'b1;
    drive(1'b1, BASE + 32'h0, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    repeat (3) idle();

    chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
